fir_tap_sequencer: RTL and testbench



---
 rtl/fir_tap_sequencer_if.sv | 25 ++
 rtl/fir_tap_sequencer.sv | 82 ++++++++
 tb/tb_fir_tap_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample, coefficient-write and result handshake bundle for the FIR tap sequencer
interface fir_tap_sequencer_if #(
    parameter int N  = 16,
    parameter int CW = 6,
    parameter int AW = 2
);
    logic [N-1:0]  data_in;
    logic          in_valid;
    logic          in_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic [N-1:0]  data_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    modport master (
        output data_in, in_valid, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, data_out, out_valid, busy
    );
    modport slave (
        input  data_in, in_valid, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, data_out, out_valid, busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR, one shared multiplier and accumulator stepping one tap per clock
module fir_tap_sequencer #(
    parameter int N     = 16,
    parameter int CW    = 6,
    parameter int TAPS  = 4,
    parameter int AW    = 2,
    parameter int SHIFT = 7
) (
    input logic clk,
    input logic reset,
    fir_tap_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
    state_t                state_q, state_d;
    logic [AW-1:0]         tap_q, tap_d;
    logic [N+CW+AW-1:0]    acc_q, acc_d, acc_sum;
    logic [N+CW-1:0]       prod;
    logic [N-1:0]          x_q [TAPS];
    logic [N-1:0]          x_d [TAPS];
    logic [CW-1:0]         coef_q [TAPS];
    logic [CW-1:0]         coef_d [TAPS];
    logic [N-1:0]          dout_q, dout_d;
    logic                  ovalid_q, ovalid_d;
    assign prod    = {{CW{1'b0}}, x_q[tap_q]} * {{N{1'b0}}, coef_q[tap_q]};
    assign acc_sum = acc_q + {{AW{1'b0}}, prod};
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        acc_d    = acc_q;
        x_d      = x_q;
        coef_d   = coef_q;
        dout_d   = dout_q;
        ovalid_d = ovalid_q;
        // coefficient bank is only writable between samples
        if (state_q == IDLE && bus.coef_we)
            coef_d[bus.coef_addr] = bus.coef_data;
        if (state_q == IDLE && bus.in_valid) begin
            x_d[0] = bus.data_in;
            for (int k = 1; k < TAPS; k++)
                x_d[k] = x_q[k-1];
            acc_d   = '0;
            tap_d   = '0;
            state_d = MAC;
        end else if (state_q == MAC) begin
            acc_d = acc_sum;
            tap_d = tap_q + 1'b1;
            if (tap_q == AW'(TAPS - 1)) begin
                dout_d   = N'(acc_sum >> SHIFT);
                ovalid_d = 1'b1;
                state_d  = HOLD;
            end
        end else if (state_q == HOLD && bus.out_ready) begin
            ovalid_d = 1'b0;
            state_d  = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            acc_q    <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= CW'(32);
            end
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
        end
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.data_out  = dout_q;
    assign bus.out_valid = ovalid_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed self-checking bench for the FIR tap sequencer
module tb_fir_tap_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    fir_tap_sequencer_if #(.N(16), .CW(6), .AW(2)) bus ();
    fir_tap_sequencer #(.N(16), .CW(6), .TAPS(4), .AW(2), .SHIFT(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic wr(input logic [1:0] a, input logic [5:0] d);
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        @(negedge clk);
        bus.coef_we   = 1'b0;
    endtask
    // accept one sample, measure latency to out_valid, check result, optionally drain
    task automatic send(input logic [15:0] v, input logic [15:0] exp, input bit mac_wr,
                        input bit drain, input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
        bus.data_in  = v;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_in_ready_busy"}, bus.in_ready, 0);
        if (mac_wr) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 2'd0;
            bus.coef_data = 6'd0;
        end
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.coef_we = 1'b0;
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_data_out"}, bus.data_out, exp);
        if (drain) begin
            @(negedge clk);
            chk({tag, "_out_valid_drop"}, bus.out_valid, 0);
            chk({tag, "_in_ready_back"}, bus.in_ready, 1);
        end
    endtask
    initial begin
        reset         = 1'b1;
        bus.data_in   = '0;
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_data_out", bus.data_out, 0);
        send(16'd100, 16'd25, 0, 1, "avg1");
        send(16'd200, 16'd75, 0, 1, "avg2");
        send(16'd300, 16'd150, 0, 1, "avg3");
        send(16'd400, 16'd250, 0, 1, "avg4");
        bus.out_ready = 1'b0;
        send(16'd500, 16'd350, 0, 0, "bp");
        bus.in_valid = 1'b1;
        bus.data_in  = 16'd999;
        repeat (10) begin
            @(negedge clk);
            chk("bp_data_out", bus.data_out, 350);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        send(16'd0, 16'd300, 0, 1, "bp_hist");
        pulse_reset();
        wr(2'd0, 6'd63);
        wr(2'd1, 6'd0);
        wr(2'd2, 6'd0);
        wr(2'd3, 6'd0);
        send(16'd1024, 16'd504, 1, 1, "coef_a");
        send(16'd1024, 16'd504, 0, 1, "coef_drop");
        pulse_reset();
        for (int k = 0; k < 4; k++) wr(k[1:0], 6'd63);
        send(16'hFFFF, 16'd32255, 0, 1, "wrap1");
        send(16'hFFFF, 16'd64511, 0, 1, "wrap2");
        send(16'hFFFF, 16'd31230, 0, 1, "wrap3");
        send(16'hFFFF, 16'd63486, 0, 1, "wrap4");
        @(negedge clk);
        bus.data_in  = 16'd777;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_data_out", bus.data_out, 0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_output", bus.out_valid, 0);
        end
        send(16'd400, 16'd100, 0, 1, "after_abort");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
